// File: rtl/coherence_bus_ctrl.sv
// Two-CPU snooping bus controller: round-robin arbitration, one transaction at a time,
// peer-cache snoop, fill-source selection (peer or unified memory) and invalidate broadcast.
module coherence_bus_ctrl #(
    parameter int ADDR_W    = 11,
    parameter int SNOOP_LAT = 1,
    parameter int MEM_TMO   = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        read_miss,
    input  logic [1:0]        write_miss,
    input  logic [1:0]        invalidate,
    input  logic [ADDR_W-1:0] bico0,
    input  logic [ADDR_W-1:0] bico1,
    input  logic [1:0]        found,
    input  logic              u_rdy,
    output logic [1:0]        grant,
    output logic [1:0]        cpu_search,
    output logic [ADDR_W+1:0] boci,
    output logic [1:0]        cpu_datasel0,
    output logic [1:0]        cpu_datasel1,
    output logic [1:0]        inv_other,
    output logic              bus_busy,
    output logic              bus_err
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SNOOP = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_XFER  = 3'd3;
    localparam logic [2:0] S_MEM   = 3'd4;
    localparam logic [2:0] S_INVAL = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    localparam logic [1:0] OP_RD  = 2'b01;
    localparam logic [1:0] OP_WR  = 2'b10;
    localparam logic [1:0] OP_INV = 2'b11;

    localparam int TMO_W = $clog2(MEM_TMO + 1);
    localparam int LAT_W = $clog2(SNOOP_LAT + 1);
    localparam int MAX_W = (TMO_W > LAT_W) ? TMO_W : LAT_W;
    localparam int CNT_W = (MAX_W > 8) ? MAX_W : 8;

    localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(SNOOP_LAT - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(MEM_TMO - 1);

    logic [2:0]        r_state;
    logic              r_owner;
    logic              r_rr;
    logic              r_err;
    logic [CNT_W-1:0]  r_cnt;
    logic [1:0]        r_op;
    logic [ADDR_W-1:0] r_addr;

    logic [1:0] w_req;
    logic       w_pick;
    logic [1:0] w_op_pick;
    logic       w_peer;
    logic       w_active;
    logic [1:0] w_own_mask;
    logic [1:0] w_peer_mask;
    logic [1:0] w_sel;

    assign w_req     = read_miss | write_miss | invalidate;
    // Contention goes to the round-robin pointer; a lone requester always wins.
    assign w_pick    = (w_req == 2'b11) ? r_rr : w_req[1];
    assign w_op_pick = invalidate[w_pick] ? OP_INV :
                       write_miss[w_pick] ? OP_WR  : OP_RD;
    assign w_peer    = ~r_owner;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_owner <= 1'b0;
            r_rr    <= 1'b0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (|w_req) begin
                        r_owner <= w_pick;
                        r_state <= S_SNOOP;
                    end
                end
                S_SNOOP: begin
                    r_cnt   <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (r_cnt == LAT_LAST) begin
                        r_cnt <= '0;
                        if (r_op == OP_INV)    r_state <= S_INVAL;
                        else if (found[w_peer]) r_state <= S_XFER;
                        else                    r_state <= S_MEM;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_XFER: r_state <= (r_op == OP_WR) ? S_INVAL : S_DONE;
                S_MEM: begin
                    // A completion on the final allowed cycle still counts as success.
                    if (u_rdy) begin
                        r_state <= (r_op == OP_WR) ? S_INVAL : S_DONE;
                    end else if (r_cnt == TMO_LAST) begin
                        r_err   <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_INVAL: r_state <= S_DONE;
                S_DONE: begin
                    r_rr    <= ~r_owner;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == S_IDLE && (|w_req)) begin
            r_op   <= w_op_pick;
            r_addr <= w_pick ? bico1 : bico0;
        end
    end

    assign w_active    = (r_state == S_SNOOP) || (r_state == S_WAIT) || (r_state == S_XFER) ||
                         (r_state == S_MEM)   || (r_state == S_INVAL);
    assign w_own_mask  = r_owner ? 2'b10 : 2'b01;
    assign w_peer_mask = r_owner ? 2'b01 : 2'b10;

    always_comb begin
        w_sel = 2'b00;
        if (r_state == S_XFER)     w_sel = 2'b10;
        else if (r_state == S_MEM) w_sel = 2'b01;
    end

    assign grant        = w_active ? w_own_mask : 2'b00;
    assign boci         = w_active ? {r_op, r_addr} : '0;
    assign cpu_search   = (r_state == S_SNOOP) ? w_peer_mask : 2'b00;
    assign inv_other    = (r_state == S_INVAL) ? w_peer_mask : 2'b00;
    assign cpu_datasel0 = r_owner ? 2'b00 : w_sel;
    assign cpu_datasel1 = r_owner ? w_sel : 2'b00;
    assign bus_busy     = (r_state != S_IDLE);
    assign bus_err      = r_err;

endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// Scoreboard bench for coherence_bus_ctrl: a transaction-level model predicts each bus
// transaction; a negedge monitor reconstructs what the DUT did and compares.
module tb_coherence_bus_ctrl;

    localparam int AW    = 11;
    localparam int SLAT  = 2;
    localparam int TMO   = 40;
    localparam int NEVER = 100000;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    read_miss, write_miss, invalidate;
    logic [AW-1:0] bico0, bico1;
    logic [1:0]    found;
    logic          u_rdy;
    logic [1:0]    grant, cpu_search, cpu_datasel0, cpu_datasel1, inv_other;
    logic [AW+1:0] boci;
    logic          bus_busy, bus_err;

    coherence_bus_ctrl #(.ADDR_W(AW), .SNOOP_LAT(SLAT), .MEM_TMO(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .read_miss(read_miss), .write_miss(write_miss), .invalidate(invalidate),
        .bico0(bico0), .bico1(bico1), .found(found), .u_rdy(u_rdy),
        .grant(grant), .cpu_search(cpu_search), .boci(boci),
        .cpu_datasel0(cpu_datasel0), .cpu_datasel1(cpu_datasel1),
        .inv_other(inv_other), .bus_busy(bus_busy), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    typedef struct {
        int owner;
        int boci;
        int gcyc;
        int npeer;
        int nmem;
        int inv;
        int err;
        int lkind;
        int issue;
    } exp_t;

    exp_t q[$];
    int   m_rr, m_err;
    int   hit_a[2];
    int   dly_a[2];
    bit   mon_en;

    // Reference model: one predicted transaction from the protocol rules.
    task automatic model_txn(input int o, input int lk, input int issue, input int opc, input int addr);
        exp_t e;
        e.owner = o;
        e.boci  = opc * (1 << AW) + addr;
        e.npeer = 0;
        e.nmem  = 0;
        e.inv   = 0;
        if (opc == 3) begin
            e.inv = 1;
        end else if (hit_a[o] != 0) begin
            e.npeer = 1;
            e.inv   = (opc == 2) ? 1 : 0;
        end else if (dly_a[o] < TMO) begin
            e.nmem = dly_a[o] + 1;
            e.inv  = (opc == 2) ? 1 : 0;
        end else begin
            e.nmem = TMO;
            m_err  = 1;
        end
        e.gcyc  = 1 + SLAT + e.npeer + e.nmem + e.inv;
        e.err   = m_err;
        e.lkind = lk;
        e.issue = issue;
        m_rr    = 1 - o;
        q.push_back(e);
    endtask

    function automatic int opcode(input logic [2:0] rb);
        if (rb[2]) return 3;
        if (rb[1]) return 2;
        return 1;
    endfunction

    // Driver: issue one stimulus item (one or both cpus requesting) and hold
    // each request until that cpu's grant falls.
    task automatic issue_item(input int mask, input logic [2:0] rb0, input logic [2:0] rb1,
                              input int h0, input int h1, input int d0, input int d1,
                              input int a0, input int a1);
        int first, remaining, budget, own;
        logic [1:0] pg;
        budget = 0;
        while (bus_busy && budget < 1000) begin
            @(negedge clk);
            budget++;
        end
        if (bus_busy) chk("bus_idle_wait", 1, 0);
        hit_a[0] = h0; hit_a[1] = h1;
        dly_a[0] = d0; dly_a[1] = d1;
        bico0 = AW'(a0);
        bico1 = AW'(a1);
        read_miss  = {mask[1] & rb1[0], mask[0] & rb0[0]};
        write_miss = {mask[1] & rb1[1], mask[0] & rb0[1]};
        invalidate = {mask[1] & rb1[2], mask[0] & rb0[2]};
        first = (mask == 3) ? m_rr : ((mask == 2) ? 1 : 0);
        model_txn(first, 0, cyc, opcode(first ? rb1 : rb0), first ? a1 : a0);
        if (mask == 3) model_txn(1 - first, 1, cyc, opcode(first ? rb0 : rb1), first ? a0 : a1);
        remaining = mask;
        pg = 2'b00;
        own = 0;
        budget = 0;
        while (remaining != 0 && budget < 600) begin
            @(negedge clk);
            budget++;
            if (grant != 2'b00 && pg == 2'b00) begin
                own = grant[1] ? 1 : 0;
                // The owner's address is latched; wiggle it to expose any re-sampling.
                if (own == 1) bico1 = AW'($urandom);
                else          bico0 = AW'($urandom);
            end
            if (grant == 2'b00 && pg != 2'b00) begin
                read_miss[own]  = 1'b0;
                write_miss[own] = 1'b0;
                invalidate[own] = 1'b0;
                remaining = remaining & ~(1 << own);
            end
            pg = grant;
        end
        if (remaining != 0) begin
            chk("item_completion", remaining, 0);
            read_miss = 2'b00; write_miss = 2'b00; invalidate = 2'b00;
        end
    endtask

    // Snoop responder: found[peer] carries the hit only on the sampling cycle,
    // the opposite value on the other WAIT cycles, noise elsewhere.
    int wc = 0;
    int fo = 0;
    always @(negedge clk) begin
        logic [1:0] f;
        f = 2'($urandom);
        if (cpu_search != 2'b00) begin
            fo = grant[1] ? 1 : 0;
            f[1 - fo] = (hit_a[fo] == 0);
            wc = 1;
        end else if (wc >= 1 && wc <= SLAT) begin
            f[1 - fo] = (wc == SLAT) ? (hit_a[fo] != 0) : (hit_a[fo] == 0);
            wc++;
        end else begin
            wc = 0;
        end
        found = f;
    end

    // Memory responder: u_rdy on MEM cycle dly (0-based), noise outside MEM.
    int mk = 0;
    always @(negedge clk) begin
        if ((grant[0] && cpu_datasel0 == 2'b01) || (grant[1] && cpu_datasel1 == 2'b01)) begin
            u_rdy = (mk == dly_a[grant[1] ? 1 : 0]);
            mk++;
        end else begin
            mk = 0;
            u_rdy = 1'($urandom);
        end
    end

    // Monitor: rebuild each transaction from the outputs and score it.
    logic [1:0] pg_m = 2'b00;
    logic [1:0] om, pm, so, sx;
    int mo_own, mo_boci, mo_rise, mo_len, mo_ns, mo_sf, mo_np, mo_nm, mo_ni, mo_li, mo_bad;
    int mo_fall = 0;
    int idle_bad = 0;
    always @(negedge clk) begin
        exp_t e;
        if (!mon_en) begin
            pg_m = 2'b00;
        end else begin
            if (grant != 2'b00) begin
                if (pg_m == 2'b00) begin
                    mo_own  = grant[1] ? 1 : 0;
                    mo_boci = int'(boci);
                    mo_rise = cyc;
                    mo_len = 0; mo_ns = 0; mo_np = 0; mo_nm = 0; mo_ni = 0; mo_bad = 0;
                    mo_sf = (cpu_search == (grant[1] ? 2'b01 : 2'b10)) ? 1 : 0;
                end
                om = mo_own ? 2'b10 : 2'b01;
                pm = ~om;
                so = mo_own ? cpu_datasel1 : cpu_datasel0;
                sx = mo_own ? cpu_datasel0 : cpu_datasel1;
                mo_len++;
                if (grant != om || !bus_busy || int'(boci) != mo_boci) mo_bad++;
                if ((cpu_search & om) != 0 || (inv_other & om) != 0) mo_bad++;
                if (sx != 2'b00 || so == 2'b11) mo_bad++;
                if (cpu_search == pm) mo_ns++;
                if (so == 2'b10) mo_np++;
                if (so == 2'b01) mo_nm++;
                mo_li = (inv_other == pm) ? 1 : 0;
                mo_ni += mo_li;
            end else if (pg_m != 2'b00) begin
                if (q.size() == 0) begin
                    chk("unexpected_txn", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("owner", mo_own, e.owner);
                    chk("boci", mo_boci, e.boci);
                    chk("grant_cycles", mo_len, e.gcyc);
                    chk("search_pulses", mo_ns, 1);
                    chk("search_first", mo_sf, 1);
                    chk("sel_peer_cycles", mo_np, e.npeer);
                    chk("sel_mem_cycles", mo_nm, e.nmem);
                    chk("inv_pulses", mo_ni, e.inv);
                    chk("inv_last", mo_li, e.inv);
                    chk("invariants", mo_bad, 0);
                    chk("done_outputs", (boci == 0 && cpu_datasel0 == 0 && cpu_datasel1 == 0 &&
                                         inv_other == 0 && cpu_search == 0 && bus_busy) ? 1 : 0, 1);
                    chk("bus_err", bus_err, e.err);
                    if (e.lkind == 0) chk("grant_latency", mo_rise - e.issue, 1);
                    else              chk("b2b_gap", mo_rise - mo_fall, 2);
                end
                mo_fall = cyc;
            end else begin
                if ((cpu_search | inv_other | cpu_datasel0 | cpu_datasel1) != 0 || boci != 0)
                    idle_bad++;
            end
            pg_m = grant;
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int mask, budget;
        logic [2:0] r0, r1;
        rst_n = 1'b0;
        read_miss = 0; write_miss = 0; invalidate = 0;
        bico0 = 0; bico1 = 0; found = 0; u_rdy = 0;
        mon_en = 0; m_rr = 0; m_err = 0;
        hit_a[0] = 0; hit_a[1] = 0; dly_a[0] = 0; dly_a[1] = 0;
        repeat (3) @(negedge clk);
        chk("rst_grant", grant, 0);
        chk("rst_boci", boci, 0);
        chk("rst_busy_err", {bus_busy, bus_err}, 0);
        chk("rst_strobes", {cpu_search, inv_other, cpu_datasel0, cpu_datasel1}, 0);
        rst_n = 1'b1;
        mon_en = 1;
        @(negedge clk);

        issue_item(1, 3'b001, 3'b000, 0, 0, 4, 0, 'h123, 0);
        issue_item(2, 3'b000, 3'b010, 0, 1, 0, 0, 0, 'h7FF);
        issue_item(3, 3'b001, 3'b001, 0, 0, 1, 2, 'h011, 'h022);
        issue_item(3, 3'b001, 3'b001, 1, 0, 0, 3, 'h033, 'h044);
        issue_item(1, 3'b100, 3'b000, 0, 0, 0, 0, 'h040, 0);
        issue_item(1, 3'b001, 3'b000, 0, 0, NEVER, 0, 'h155, 0);
        issue_item(2, 3'b000, 3'b001, 0, 0, 0, 2, 0, 'h2AA);
        issue_item(2, 3'b000, 3'b011, 0, 0, 0, TMO - 1, 0, 'h301);
        issue_item(1, 3'b010, 3'b000, 0, 0, TMO, 0, 'h302, 0);
        issue_item(3, 3'b111, 3'b110, 0, 1, 0, 0, 'h3FF, 'h001);

        for (int i = 0; i < 120; i++) begin
            mask = $urandom_range(1, 3);
            r0 = 3'($urandom_range(1, 7));
            r1 = 3'($urandom_range(1, 7));
            issue_item(mask, r0, r1, $urandom_range(0, 1), $urandom_range(0, 1),
                       ($urandom_range(0, 7) == 0) ? $urandom_range(TMO - 2, TMO + 2) : $urandom_range(0, 6),
                       ($urandom_range(0, 7) == 0) ? $urandom_range(TMO - 2, TMO + 2) : $urandom_range(0, 6),
                       $urandom_range(0, (1 << AW) - 1), $urandom_range(0, (1 << AW) - 1));
        end
        repeat (3) @(negedge clk);

        // Reset in the middle of a memory wait.
        mon_en = 0;
        hit_a[1] = 0; dly_a[1] = NEVER;
        read_miss = 2'b10;
        budget = 0;
        while (cpu_datasel1 != 2'b01 && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        chk("reach_mem", cpu_datasel1, 2'b01);
        read_miss = 2'b00;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_grant_boci", {grant, boci}, 0);
        chk("midrst_strobes", {cpu_search, inv_other, cpu_datasel0, cpu_datasel1}, 0);
        chk("midrst_busy_err", {bus_busy, bus_err}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_rr = 0; m_err = 0;
        q.delete();
        mon_en = 1;
        @(negedge clk);
        issue_item(3, 3'b001, 3'b001, 0, 1, 2, 0, 'h0AB, 'h0CD);
        issue_item(1, 3'b010, 3'b000, 1, 0, 0, 0, 'h5A5, 0);
        repeat (3) @(negedge clk);

        chk("queue_empty", q.size(), 0);
        chk("idle_outputs", idle_bad, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
